// File: rtl/gap_tv_diff_sched_if.sv
// Bundle of start/done control, BRAM read side and result write side for gap_tv_diff_sched.
// The pause input exists only when GAP_TV_SCHED_PAUSE_EN is defined.
interface gap_tv_diff_sched_if #(
    parameter int ADDR_W  = 8,
    parameter int FRAME_W = 7
);
    logic               start;
    logic [FRAME_W-1:0] f_num;
`ifdef GAP_TV_SCHED_PAUSE_EN
    logic               pause;
`endif
    logic               busy;
    logic               done;
    logic               ren;
    logic [ADDR_W-1:0]  raddr;
    logic [FRAME_W-1:0] rframe;
    logic               dp_row_clr;
    logic               wen;
    logic [ADDR_W-1:0]  waddr;
    logic [FRAME_W-1:0] wframe;

`ifdef GAP_TV_SCHED_PAUSE_EN
    modport master (
        input  start, f_num, pause,
        output busy, done, ren, raddr, rframe, dp_row_clr, wen, waddr, wframe
    );
    modport slave (
        output start, f_num, pause,
        input  busy, done, ren, raddr, rframe, dp_row_clr, wen, waddr, wframe
    );
`else
    modport master (
        input  start, f_num,
        output busy, done, ren, raddr, rframe, dp_row_clr, wen, waddr, wframe
    );
    modport slave (
        output start, f_num,
        input  busy, done, ren, raddr, rframe, dp_row_clr, wen, waddr, wframe
    );
`endif
endinterface

// File: rtl/gap_tv_diff_sched.sv
// GAP-TV dx-difference sequencer: scans frames right-to-left per row and writes results LAT cycles later.
// Define GAP_TV_SCHED_PAUSE_EN to add a pause input that stalls the read scan in RUN.
module gap_tv_diff_sched #(
    parameter int ROW_NUM   = 48,
    parameter int COL_WIDTH = 2,
    parameter int ADDR_W    = 8,
    parameter int LAT       = 4,
    parameter int FRAME_W   = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    gap_tv_diff_sched_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [ADDR_W-1:0]  LAST_ROW = ADDR_W'(ROW_NUM - 1);
    localparam logic [ADDR_W-1:0]  LAST_COL = ADDR_W'(COL_WIDTH - 1);
    localparam logic [ADDR_W-1:0]  ROW_LEN  = ADDR_W'(COL_WIDTH);
    localparam logic [ADDR_W-1:0]  ONE_A    = ADDR_W'(1);
    localparam logic [FRAME_W-1:0] ONE_F    = FRAME_W'(1);

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  row, row_nx, col, col_nx;
    logic [FRAME_W-1:0] frame, frame_nx, f_total, f_total_nx;
    logic [ADDR_W-1:0]  pos_row, pos_col;
    logic [FRAME_W-1:0] pos_frame, frames;
    logic               issue, last, inflight, paused;

    logic               ren_q, ren_nx, clr_q, clr_nx, busy_q, done_q;
    logic [ADDR_W-1:0]  raddr_q, raddr_nx;
    logic [FRAME_W-1:0] rframe_q, rframe_nx;

    logic               pipe_v [1:LAT];
    logic [ADDR_W-1:0]  pipe_a [1:LAT];
    logic [FRAME_W-1:0] pipe_f [1:LAT];

`ifdef GAP_TV_SCHED_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    // Any valid read still travelling towards the write port keeps DRAIN alive.
    always_comb begin
        inflight = ren_q;
        for (int i = 1; i < LAT; i++) begin
            inflight = inflight | pipe_v[i];
        end
    end

    // The first read of a job is issued on the same edge that accepts start, so IDLE
    // presents the scan origin while RUN presents the stored scan position.
    always_comb begin
        state_nx   = state;
        row_nx     = row;
        col_nx     = col;
        frame_nx   = frame;
        f_total_nx = f_total;
        ren_nx     = 1'b0;
        clr_nx     = 1'b0;
        raddr_nx   = '0;
        rframe_nx  = '0;
        issue      = 1'b0;

        if (state == IDLE) begin
            pos_row   = '0;
            pos_col   = LAST_COL;
            pos_frame = '0;
            frames    = bus.f_num;
        end else begin
            pos_row   = row;
            pos_col   = col;
            pos_frame = frame;
            frames    = f_total;
        end
        last = (pos_frame == frames - ONE_F) && (pos_row == LAST_ROW) && (pos_col == '0);

        case (state)
            IDLE: begin
                if (bus.start) begin
                    f_total_nx = bus.f_num;
                    if (bus.f_num == '0) state_nx = FIN;
                    else                 issue    = 1'b1;
                end
            end
            RUN:     issue = !paused;
            DRAIN:   if (!inflight) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (issue) begin
            ren_nx    = 1'b1;
            raddr_nx  = pos_row * ROW_LEN + pos_col;
            rframe_nx = pos_frame;
            clr_nx    = (pos_col == LAST_COL);
            state_nx  = last ? DRAIN : RUN;
            frame_nx  = pos_frame;
            row_nx    = pos_row;
            if (pos_col != '0) begin
                col_nx = pos_col - ONE_A;
            end else begin
                col_nx = LAST_COL;
                if (pos_row != LAST_ROW) begin
                    row_nx = pos_row + ONE_A;
                end else begin
                    row_nx   = '0;
                    frame_nx = pos_frame + ONE_F;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            frame    <= '0;
            f_total  <= '0;
            ren_q    <= 1'b0;
            clr_q    <= 1'b0;
            raddr_q  <= '0;
            rframe_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 1; i <= LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_f[i] <= '0;
            end
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            col      <= col_nx;
            frame    <= frame_nx;
            f_total  <= f_total_nx;
            ren_q    <= ren_nx;
            clr_q    <= clr_nx;
            raddr_q  <= raddr_nx;
            rframe_q <= rframe_nx;
            busy_q   <= (state_nx != IDLE);
            done_q   <= (state_nx == FIN);
            pipe_v[1] <= ren_q;
            pipe_a[1] <= raddr_q;
            pipe_f[1] <= rframe_q;
            for (int i = 2; i <= LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
                pipe_f[i] <= pipe_f[i-1];
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ren        = ren_q;
    assign bus.raddr      = raddr_q;
    assign bus.rframe     = rframe_q;
    assign bus.dp_row_clr = clr_q;
    assign bus.wen        = pipe_v[LAT];
    assign bus.waddr      = pipe_a[LAT];
    assign bus.wframe     = pipe_f[LAT];
endmodule

// File: tb/tb_gap_tv_diff_sched.sv
// Self-checking bench for gap_tv_diff_sched against a cycle-indexed read/write schedule model.
// Pause scenarios are compiled in only when GAP_TV_SCHED_PAUSE_EN is defined.
module tb_gap_tv_diff_sched;
    localparam int ROW_NUM   = 48;
    localparam int COL_WIDTH = 2;
    localparam int ADDR_W    = 8;
    localparam int LAT       = 4;
    localparam int FRAME_W   = 7;
    localparam int MAXC      = 512;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               ren;
        logic               clr;
        logic [ADDR_W-1:0]  raddr;
        logic [FRAME_W-1:0] rframe;
        logic               wen;
        logic [ADDR_W-1:0]  waddr;
        logic [FRAME_W-1:0] wframe;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gap_tv_diff_sched_if #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) bus ();

    gap_tv_diff_sched #(
        .ROW_NUM(ROW_NUM), .COL_WIDTH(COL_WIDTH), .ADDR_W(ADDR_W), .LAT(LAT), .FRAME_W(FRAME_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    obs_t exp_tr [0:MAXC-1];
    int   exp_len;
    int   exp_done_cycle;
    int   checks = 0;
    int   failures = 0;

    // Expected trace: reads in scan order, one per cycle unless the preceding edge sampled pause.
    task automatic build_model(input int fnum, input int pfirst, input int plen);
        int n, k, c, last_c, fr, row, col;
        for (int i = 0; i < MAXC; i++) exp_tr[i] = '0;
        n = fnum * ROW_NUM * COL_WIDTH;
        k = 0;
        c = 1;
        last_c = 0;
        while (k < n) begin
            if (c == 1 || (c - 1) < pfirst || (c - 1) >= pfirst + plen) begin
                fr  = k / (ROW_NUM * COL_WIDTH);
                row = (k / COL_WIDTH) % ROW_NUM;
                col = COL_WIDTH - 1 - (k % COL_WIDTH);
                exp_tr[c].ren    = 1'b1;
                exp_tr[c].raddr  = ADDR_W'(row * COL_WIDTH + col);
                exp_tr[c].rframe = FRAME_W'(fr);
                exp_tr[c].clr    = (col == COL_WIDTH - 1);
                exp_tr[c+LAT].wen    = 1'b1;
                exp_tr[c+LAT].waddr  = ADDR_W'(row * COL_WIDTH + col);
                exp_tr[c+LAT].wframe = FRAME_W'(fr);
                k++;
                last_c = c;
            end
            c++;
        end
        exp_done_cycle = (n == 0) ? 1 : last_c + LAT + 1;
        for (int i = 1; i <= exp_done_cycle; i++) exp_tr[i].busy = 1'b1;
        exp_tr[exp_done_cycle].done = 1'b1;
        exp_len = exp_done_cycle + 2;
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy   = bus.busy;
        o.done   = bus.done;
        o.ren    = bus.ren;
        o.clr    = bus.dp_row_clr;
        o.raddr  = bus.ren ? bus.raddr : '0;
        o.rframe = bus.ren ? bus.rframe : '0;
        o.wen    = bus.wen;
        o.waddr  = bus.wen ? bus.waddr : '0;
        o.wframe = bus.wen ? bus.wframe : '0;
        return o;
    endfunction

    function automatic obs_t sample_raw();
        obs_t o;
        o = {bus.busy, bus.done, bus.ren, bus.dp_row_clr, bus.raddr, bus.rframe,
             bus.wen, bus.waddr, bus.wframe};
        return o;
    endfunction

    task automatic step(input logic st, input logic [FRAME_W-1:0] fn);
        bus.start = st;
        bus.f_num = fn;
        @(posedge clk);
        #1;
    endtask

`ifdef GAP_TV_SCHED_PAUSE_EN
    task automatic set_pause(input int edge_idx, input int pfirst, input int plen);
        bus.pause = (edge_idx >= pfirst && edge_idx < pfirst + plen);
    endtask
`endif

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b0;
        step(1'b0, '0);
        step(1'b1, FRAME_W'(3));
        step(1'b1, FRAME_W'(3));
        o = sample_raw();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", o, obs_t'('0));
        end
        rst_n = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        o = sample_raw();
        checks++;
        if (o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got %h expected %h", o, obs_t'('0));
        end
    endtask

    task automatic test_single_frame();
        obs_t o;
        int clr_cnt = 0, done_at = -1, first_wen = -1;
        build_model(1, 0, 0);
        step(1'b1, FRAME_W'(1));
        for (int c = 1; c < exp_len; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL single_frame cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            if (o.clr) clr_cnt++;
            if (o.done && done_at < 0) done_at = c;
            if (o.wen && first_wen < 0) first_wen = c;
            step(1'b0, FRAME_W'(1));
        end
        checks++;
        if (clr_cnt !== ROW_NUM) begin
            failures++;
            $display("[TB] FAIL single_frame clr_pulses: got %0d expected %0d", clr_cnt, ROW_NUM);
        end
        checks++;
        if (done_at !== 101) begin
            failures++;
            $display("[TB] FAIL single_frame done_cycle: got %0d expected 101", done_at);
        end
        checks++;
        if (first_wen !== 5) begin
            failures++;
            $display("[TB] FAIL single_frame first_wen: got %0d expected 5", first_wen);
        end
    endtask

    task automatic test_two_frames();
        obs_t o;
        int done_at = -1;
        build_model(2, 0, 0);
        step(1'b1, FRAME_W'(2));
        for (int c = 1; c < exp_len; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL two_frames cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            if (o.done && done_at < 0) done_at = c;
            step(1'b0, FRAME_W'(2));
        end
        checks++;
        if (done_at !== 197) begin
            failures++;
            $display("[TB] FAIL two_frames done_cycle: got %0d expected 197", done_at);
        end
    endtask

    task automatic test_zero_frames();
        obs_t o;
        build_model(0, 0, 0);
        step(1'b1, '0);
        for (int c = 1; c < exp_len + 3; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL zero_frames cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            step(1'b0, '0);
        end
    endtask

    task automatic test_start_ignored();
        obs_t o;
        build_model(1, 0, 0);
        step(1'b1, FRAME_W'(1));
        for (int c = 1; c < exp_len; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL start_ignored cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            if (c == 20) step(1'b1, FRAME_W'(5));
            else         step(1'b0, FRAME_W'(5));
        end
    endtask

    task automatic test_reset_mid_job();
        obs_t o;
        build_model(1, 0, 0);
        step(1'b1, FRAME_W'(1));
        for (int c = 1; c <= 50; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL reset_mid_job cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            if (c == 50) rst_n = 1'b0;
            step(1'b0, FRAME_W'(1));
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            o = sample_raw();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("[TB] FAIL reset_flush +%0d: got %h expected %h", c, o, obs_t'('0));
            end
            step(1'b0, FRAME_W'(1));
        end
        build_model(1, 0, 0);
        step(1'b1, FRAME_W'(1));
        checks++;
        if (bus.raddr !== ADDR_W'(1) || bus.rframe !== '0 || bus.ren !== 1'b1) begin
            failures++;
            $display("[TB] FAIL restart_first_read: got ren=%b raddr=%0d rframe=%0d expected ren=1 raddr=1 rframe=0",
                     bus.ren, bus.raddr, bus.rframe);
        end
        for (int c = 1; c < exp_len; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL restart_job cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            step(1'b0, FRAME_W'(1));
        end
    endtask

`ifdef GAP_TV_SCHED_PAUSE_EN
    task automatic test_pause();
        obs_t o;
        int done_at = -1;
        build_model(1, 30, 10);
        step(1'b1, FRAME_W'(1));
        for (int c = 1; c < exp_len; c++) begin
            o = sample();
            checks++;
            if (o !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL pause cycle %0d: got %h expected %h", c, o, exp_tr[c]);
            end
            if (o.done && done_at < 0) done_at = c;
            set_pause(c, 30, 10);
            step(1'b0, FRAME_W'(1));
        end
        bus.pause = 1'b0;
        checks++;
        if (done_at !== 111) begin
            failures++;
            $display("[TB] FAIL pause done_cycle: got %0d expected 111", done_at);
        end
    endtask
`endif

    task automatic test_random_jobs();
        obs_t o;
        int fn, noise_c, pf, pl;
        for (int j = 0; j < 4; j++) begin
            fn = int'($urandom_range(1, 3));
            noise_c = int'($urandom_range(2, 90));
`ifdef GAP_TV_SCHED_PAUSE_EN
            pf = int'($urandom_range(3, 150));
            pl = int'($urandom_range(1, 12));
`else
            pf = 0;
            pl = 0;
`endif
            build_model(fn, pf, pl);
            step(1'b1, FRAME_W'(fn));
            for (int c = 1; c < exp_len; c++) begin
                o = sample();
                checks++;
                if (o !== exp_tr[c]) begin
                    failures++;
                    $display("[TB] FAIL random_job%0d f_num=%0d cycle %0d: got %h expected %h",
                             j, fn, c, o, exp_tr[c]);
                end
`ifdef GAP_TV_SCHED_PAUSE_EN
                set_pause(c, pf, pl);
`endif
                if (c == noise_c) step(1'b1, FRAME_W'($urandom_range(0, 127)));
                else              step(1'b0, FRAME_W'(fn));
            end
`ifdef GAP_TV_SCHED_PAUSE_EN
            bus.pause = 1'b0;
`endif
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.f_num = '0;
`ifdef GAP_TV_SCHED_PAUSE_EN
        bus.pause = 1'b0;
`endif
        #1;
        test_reset();
        test_single_frame();
        test_two_frames();
        test_zero_frames();
        test_start_ignored();
        test_reset_mid_job();
`ifdef GAP_TV_SCHED_PAUSE_EN
        test_pause();
`endif
        test_random_jobs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
